// File: rtl/mem_pkg.sv
// Shared definitions for the CPU data-memory responder: word width,
// responder state encoding, request op encoding and address helpers.
package mem_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  // True when a byte address lies at or beyond the end of storage.
  // The comparison is done one bit wider so DEPTH*4 == 2**32 still works.
  function automatic logic addr_oob(input logic [WORD_W-1:0] addr,
                                    input logic [WORD_W:0]   limit);
    return ({1'b0, addr} >= limit);
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage for the data-memory responder: DEPTH x WORD_W, one
// synchronous write port and two asynchronous read ports (access + debug).
// Contents are deliberately not reset.
module data_mem_array
  import mem_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata,
  input  logic [AW-1:0]     dbg_raddr,
  output logic [WORD_W-1:0] dbg_rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Commit a store on the clock edge when the write enable is set.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata     = mem_q[raddr];
  assign dbg_rdata = mem_q[dbg_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU data-memory interface. Accepts one
// load/store at a time, waits LATENCY cycles in total and completes with a
// one-cycle mem_ready pulse carrying load data and an error flag.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic              clk_cpu,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [WORD_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              mem_err,
  input  logic [WORD_W-1:0] dbg_addr,
  output logic [WORD_W-1:0] dbg_data
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [WORD_W:0] ADDR_LIMIT = (WORD_W+1)'(DEPTH * 32'sd4);
  localparam logic [3:0]      CNT_LOAD   = 4'(LATENCY - 32'sd1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  op_t                 op_q, op_d;
  logic                err_q, err_d;
  logic                mem_ready_q, mem_ready_d;
  logic                mem_err_q, mem_err_d;
  logic [WORD_W-1:0]   mem_rdata_q, mem_rdata_d;

  logic                req_s;
  logic                req_err_s;
  logic                enter_done_s;
  logic                we_s;
  logic [WORD_W-1:0]   arr_rdata_s;
  logic [WORD_W-1:0]   arr_dbg_s;
  logic                unused_dbg_lsb_s;

  // Decode the live CPU request; only consulted while idle.
  assign req_s     = MemRead | MemWrite;
  assign req_err_s = (MemRead & MemWrite)
                   | (mem_addr[1:0] != 2'd0)
                   | addr_oob(mem_addr, ADDR_LIMIT);

  // Next-state logic: accept and latch in IDLE, count down in WAIT, pulse in DONE.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    op_d         = op_q;
    err_d        = err_q;
    enter_done_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          idx_d   = mem_addr[AW+1:2];
          wdata_d = mem_wdata;
          op_d    = MemWrite ? OP_WR : OP_RD;
          err_d   = req_err_s;
          if (LATENCY == 32'sd1) begin
            cnt_d        = 4'd0;
            state_d      = ST_DONE;
            enter_done_s = 1'b1;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        // Leave on the edge where the count reaches zero so the total
        // accept-to-ready distance is exactly LATENCY cycles.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d        = 4'd0;
          state_d      = ST_DONE;
          enter_done_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stores commit on the DONE-entry edge; a reset on that edge suppresses them.
  assign we_s = enter_done_s & (op_d == OP_WR) & ~err_d & ~reset;

  data_mem_array #(
    .DEPTH(DEPTH)
  ) u_array (
    .clk       (clk_cpu),
    .we        (we_s),
    .waddr     (idx_d),
    .wdata     (wdata_d),
    .raddr     (idx_d),
    .rdata     (arr_rdata_s),
    .dbg_raddr (dbg_addr[AW+1:2]),
    .dbg_rdata (arr_dbg_s)
  );

  // Completion outputs: registered on the DONE-entry edge, zero otherwise.
  always_comb begin
    mem_ready_d = enter_done_s;
    mem_err_d   = 1'b0;
    mem_rdata_d = {WORD_W{1'b0}};
    if (enter_done_s) begin
      mem_err_d = err_d;
      if (!err_d && (op_d == OP_RD)) begin
        mem_rdata_d = arr_rdata_s;
      end else begin
        mem_rdata_d = {WORD_W{1'b0}};
      end
    end else begin
      mem_err_d   = 1'b0;
      mem_rdata_d = {WORD_W{1'b0}};
    end
  end

  // State, request latch and output registers with synchronous reset.
  always_ff @(posedge clk_cpu) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= {AW{1'b0}};
      wdata_q     <= {WORD_W{1'b0}};
      op_q        <= OP_RD;
      err_q       <= 1'b0;
      mem_ready_q <= 1'b0;
      mem_err_q   <= 1'b0;
      mem_rdata_q <= {WORD_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      err_q       <= err_d;
      mem_ready_q <= mem_ready_d;
      mem_err_q   <= mem_err_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign mem_ready = mem_ready_q;
  assign mem_err   = mem_err_q;
  assign mem_rdata = mem_rdata_q;

  // Byte-lane bits of the debug address do not select anything.
  assign unused_dbg_lsb_s = ^dbg_addr[1:0];

  // Debug read port: storage word, or zero beyond the end of storage.
  always_comb begin
    if (addr_oob(dbg_addr, ADDR_LIMIT)) begin
      dbg_data = {WORD_W{1'b0}};
    end else begin
      dbg_data = arr_dbg_s;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with LATENCY=2 and
// one with LATENCY=1, driven from hand-written request vectors.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_s      [2];
  logic        wr_s      [2];
  logic [31:0] addr_s    [2];
  logic [31:0] wdata_s   [2];
  logic [31:0] rdata_s   [2];
  logic        ready_s   [2];
  logic        err_s     [2];
  logic [31:0] dbg_addr_s[2];
  logic [31:0] dbg_data_s[2];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .LATENCY(2)) dut (
    .clk_cpu(clk), .reset(reset),
    .MemRead(rd_s[0]), .MemWrite(wr_s[0]),
    .mem_addr(addr_s[0]), .mem_wdata(wdata_s[0]),
    .mem_rdata(rdata_s[0]), .mem_ready(ready_s[0]), .mem_err(err_s[0]),
    .dbg_addr(dbg_addr_s[0]), .dbg_data(dbg_data_s[0])
  );

  data_mem_responder #(.DEPTH(1024), .LATENCY(1)) dut1 (
    .clk_cpu(clk), .reset(reset),
    .MemRead(rd_s[1]), .MemWrite(wr_s[1]),
    .mem_addr(addr_s[1]), .mem_wdata(wdata_s[1]),
    .mem_rdata(rdata_s[1]), .mem_ready(ready_s[1]), .mem_err(err_s[1]),
    .dbg_addr(dbg_addr_s[1]), .dbg_data(dbg_data_s[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, optionally move mem_addr after accept, wait for the
  // pulse (bounded), check latency/err/rdata, then release the request.
  task automatic do_req(input int sel, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] addr_late,
                        input logic [31:0] wd, input logic exp_err,
                        input logic [31:0] exp_rdata, input string tag);
    int cyc;
    int lat;
    lat = (sel == 0) ? 2 : 1;
    rd_s[sel] = rd; wr_s[sel] = wr; addr_s[sel] = addr; wdata_s[sel] = wd;
    @(posedge clk); #1;
    cyc = 1;
    addr_s[sel] = addr_late;
    while (!ready_s[sel] && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat));
    check({tag, "_err"}, {31'd0, err_s[sel]}, {31'd0, exp_err});
    check({tag, "_rdata"}, rdata_s[sel], exp_rdata);
    rd_s[sel] = 1'b0; wr_s[sel] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop"}, {31'd0, ready_s[sel]}, 32'd0);
  endtask

  task automatic dbg_check(input int sel, input logic [31:0] addr,
                           input logic [31:0] exp, input string tag);
    dbg_addr_s[sel] = addr;
    #1;
    check(tag, dbg_data_s[sel], exp);
  endtask

  initial begin
    logic quiet;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_s[i] = 1'b0; wr_s[i] = 1'b0; addr_s[i] = 32'd0;
      wdata_s[i] = 32'd0; dbg_addr_s[i] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ready_s[0]}, 32'd0);
    check("rst_err",   {31'd0, err_s[0]},   32'd0);
    check("rst_rdata", rdata_s[0],          32'd0);
    check("rst_ready1", {31'd0, ready_s[1]}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: store then load at 0x10
    do_req(0, 1'b0, 1'b1, 32'h10, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "t1_wr");
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "t1_rd");
    dbg_check(0, 32'h10, 32'hDEADBEEF, "t1_dbg");

    // 2: misaligned load, then clean reload
    do_req(0, 1'b1, 1'b0, 32'h13, 32'h13, 32'h0, 1'b1, 32'h0, "t2_mis");
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "t2_rd");

    // 3: out-of-range store aliases word 0 in low bits; must not write
    do_req(0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h11111111, 1'b0, 32'h0, "t3_pre");
    do_req(0, 1'b0, 1'b1, 32'h1000, 32'h1000, 32'h1, 1'b1, 32'h0, "t3_oob");
    dbg_check(0, 32'h0, 32'h11111111, "t3_dbg0");
    dbg_check(0, 32'h1000, 32'h0, "t3_dbg_oob");

    // 4: read and write together
    do_req(0, 1'b0, 1'b1, 32'h20, 32'h20, 32'h22222222, 1'b0, 32'h0, "t4_pre");
    do_req(0, 1'b1, 1'b1, 32'h20, 32'h20, 32'h33333333, 1'b1, 32'h0, "t4_both");
    dbg_check(0, 32'h20, 32'h22222222, "t4_dbg");

    // address moved after accept: latched 0x10 wins over live 0x20
    do_req(0, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 1'b0, 32'hDEADBEEF, "t6_latch");

    // 5: reset during WAIT discards the store
    do_req(0, 1'b0, 1'b1, 32'h40, 32'h40, 32'hA, 1'b0, 32'h0, "t5_pre");
    rd_s[0] = 1'b0; wr_s[0] = 1'b1; addr_s[0] = 32'h40; wdata_s[0] = 32'h12345678;
    @(posedge clk); #1;
    reset = 1'b1; wr_s[0] = 1'b0;
    @(posedge clk); #1;
    check("t5_ready", {31'd0, ready_s[0]}, 32'd0);
    check("t5_err",   {31'd0, err_s[0]},   32'd0);
    check("t5_rdata", rdata_s[0],          32'd0);
    reset = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (ready_s[0]) quiet = 1'b0;
    end
    check("t5_no_pulse", {31'd0, quiet}, 32'd1);
    dbg_check(0, 32'h40, 32'hA, "t5_dbg");

    // 6: LATENCY=1 back-to-back reads with the request held
    do_req(1, 1'b0, 1'b1, 32'h80, 32'h80, 32'hAAAA0001, 1'b0, 32'h0, "t6_w0");
    do_req(1, 1'b0, 1'b1, 32'h84, 32'h84, 32'hBBBB0002, 1'b0, 32'h0, "t6_w1");
    rd_s[1] = 1'b1; addr_s[1] = 32'h80;
    @(posedge clk); #1;
    check("t6_p1_ready", {31'd0, ready_s[1]}, 32'd1);
    check("t6_p1_rdata", rdata_s[1], 32'hAAAA0001);
    addr_s[1] = 32'h84;
    @(posedge clk); #1;
    check("t6_gap_ready", {31'd0, ready_s[1]}, 32'd0);
    @(posedge clk); #1;
    check("t6_p2_ready", {31'd0, ready_s[1]}, 32'd1);
    check("t6_p2_rdata", rdata_s[1], 32'hBBBB0002);
    rd_s[1] = 1'b0;
    @(posedge clk); #1;
    check("t6_end_ready", {31'd0, ready_s[1]}, 32'd0);
    dbg_check(1, 32'h84, 32'hBBBB0002, "t6_dbg");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
